// File: rtl/serial_pkg.sv
// Shared types and constants for the serial receive path.
package serial_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Both flops reset to RESET_LEVEL.
module sync2 #(
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_LEVEL;
      q    <= RESET_LEVEL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_rx.sv
// Serial byte receiver: start detect, mid-bit sampling, framing and parity checks.
// Optional even parity is compiled in with `define SERIAL_RX_PARITY_EN.
module serial_rx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam logic [15:0] HALF_M1  = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_IDX = 3'(DATA_BITS - 1);

  rx_state_e   state, state_next;
  logic        rx_s;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  shreg;
  logic        sample_pt;
  logic        valid_next, ferr_next;
  logic        par_bad;
`ifdef SERIAL_RX_PARITY_EN
  logic        perr_next, perr_q;
`endif

  sync2 #(.RESET_LEVEL(IDLE_LEVEL)) u_sync (
    .clk   (sysclk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  // START samples at half a bit; later states sample at each full bit.
  always_comb begin
    sample_pt = 1'b0;
    case (state)
      START:              sample_pt = (cnt == HALF_M1);
      DATA, PARITY, STOP: sample_pt = (cnt == FULL_M1);
      default:            sample_pt = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    perr_next  = 1'b0;
`endif
    case (state)
      IDLE:  if (!rx_s) state_next = START;
      START: if (sample_pt) state_next = rx_s ? IDLE : DATA;
      DATA: begin
        if (sample_pt && idx == LAST_IDX) begin
`ifdef SERIAL_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      PARITY: if (sample_pt) state_next = STOP;
`endif
      STOP: begin
        if (sample_pt) begin
          if (rx_s) begin
            state_next = IDLE;
            valid_next = !par_bad;
`ifdef SERIAL_RX_PARITY_EN
            perr_next  = par_bad;
`endif
          end else begin
            // A low stop bit may be a break; wait for the line to recover.
            state_next = BREAK;
            ferr_next  = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
            perr_next  = par_bad;
`endif
          end
        end
      end
      BREAK:   if (rx_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      valid     <= valid_next;
      frame_err <= ferr_next;
      if (state == IDLE || state == BREAK || sample_pt) cnt <= '0;
      else cnt <= cnt + 16'd1;
      if (state == IDLE) idx <= '0;
      else if (state == DATA && sample_pt) begin
        shreg[idx] <= rx_s;
        idx        <= idx + 3'd1;
      end
      if (valid_next) data <= shreg;
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  // Even parity: the parity bit must equal the XOR of the data bits.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      par_bad <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      perr_q <= perr_next;
      if (state == IDLE) par_bad <= 1'b0;
      else if (state == PARITY && sample_pt) par_bad <= rx_s ^ (^shreg);
    end
  end
  assign parity_err = perr_q;
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// Directed testbench for serial_rx at CLKS_PER_BIT = 16.
// Honours SERIAL_RX_PARITY_EN to match the design build.
module tb_serial_rx;

  localparam int N = 16;
`ifdef SERIAL_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int LAT = 2 + N / 2 + (FRAME_BITS - 1) * N + 1;

  logic       sysclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic       rx     = 1'b1;
  logic [7:0] data;
  logic       valid, frame_err, parity_err, busy;

  serial_rx #(.CLKS_PER_BIT(N)) dut (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Strobe monitor: records every cycle each strobe is seen high.
  int         v_cyc[$];
  logic [7:0] v_dat[$];
  int         ferr_cnt = 0;
  int         perr_cnt = 0;
  always @(negedge sysclk) begin
    if (valid === 1'b1) begin
      v_cyc.push_back(cyc);
      v_dat.push_back(data);
    end
    if (frame_err === 1'b1) ferr_cnt++;
    if (parity_err === 1'b1) perr_cnt++;
  end

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (N) @(negedge sysclk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int fall_cyc);
    fall_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef SERIAL_RX_PARITY_EN
    drive_bit(^b);
`endif
    drive_bit(stop_bit);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge sysclk);
    checks++; if (data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_parity_err: got %b expected 0", parity_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    repeat (3) @(negedge sysclk);
  endtask

  task automatic test_good_frame();
    int base, fe0, pe0, fall, lat;
    base = v_cyc.size(); fe0 = ferr_cnt; pe0 = perr_cnt;
    send_frame(8'hA5, 1'b1, fall);
    repeat (4) @(negedge sysclk);
    lat = (v_cyc.size() > base) ? v_cyc[base] - fall : -1;
    checks++; if (v_cyc.size() - base != 1) begin errors++; $display("[TB] FAIL good_valid_count: got %0d expected 1", v_cyc.size() - base); end
    checks++; if (lat != LAT) begin errors++; $display("[TB] FAIL good_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (data !== 8'hA5) begin errors++; $display("[TB] FAIL good_data: got %h expected a5", data); end
    checks++; if (ferr_cnt - fe0 + perr_cnt - pe0 != 0) begin errors++; $display("[TB] FAIL good_no_errors: got %0d error strobes expected 0", ferr_cnt - fe0 + perr_cnt - pe0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL good_busy_idle: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    int base, fall0, fall1, gap;
    logic [7:0] d0, d1;
    base = v_cyc.size();
    send_frame(8'h3C, 1'b1, fall0);
    send_frame(8'hFF, 1'b1, fall1);
    repeat (4) @(negedge sysclk);
    checks++; if (v_cyc.size() - base != 2) begin errors++; $display("[TB] FAIL b2b_valid_count: got %0d expected 2", v_cyc.size() - base); end
    gap = (v_cyc.size() >= base + 2) ? v_cyc[base + 1] - v_cyc[base] : -1;
    d0  = (v_dat.size() >= base + 1) ? v_dat[base] : 8'hxx;
    d1  = (v_dat.size() >= base + 2) ? v_dat[base + 1] : 8'hxx;
    checks++; if (gap != FRAME_BITS * N) begin errors++; $display("[TB] FAIL b2b_gap: got %0d expected %0d", gap, FRAME_BITS * N); end
    checks++; if (d0 !== 8'h3C) begin errors++; $display("[TB] FAIL b2b_first: got %h expected 3c", d0); end
    checks++; if (d1 !== 8'hFF) begin errors++; $display("[TB] FAIL b2b_second: got %h expected ff", d1); end
  endtask

  task automatic test_glitch();
    int base, fe0, pe0;
    base = v_cyc.size(); fe0 = ferr_cnt; pe0 = perr_cnt;
    rx = 1'b0;
    repeat (4) @(negedge sysclk);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL glitch_busy_rise: got %b expected 1", busy); end
    @(negedge sysclk);
    rx = 1'b1;
    repeat (20) @(negedge sysclk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL glitch_busy_fall: got %b expected 0", busy); end
    checks++; if (v_cyc.size() - base + ferr_cnt - fe0 + perr_cnt - pe0 != 0) begin errors++; $display("[TB] FAIL glitch_no_strobe: got %0d strobes expected 0", v_cyc.size() - base + ferr_cnt - fe0 + perr_cnt - pe0); end
    checks++; if (data !== 8'hFF) begin errors++; $display("[TB] FAIL glitch_data_held: got %h expected ff", data); end
  endtask

  task automatic test_frame_err();
    int base, fe0, fall, lat;
    base = v_cyc.size(); fe0 = ferr_cnt;
    send_frame(8'h55, 1'b0, fall);
    repeat (50) @(negedge sysclk);
    checks++; if (ferr_cnt - fe0 != 1) begin errors++; $display("[TB] FAIL ferr_count: got %0d expected 1", ferr_cnt - fe0); end
    checks++; if (v_cyc.size() != base) begin errors++; $display("[TB] FAIL ferr_no_valid: got %0d expected 0", v_cyc.size() - base); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL ferr_break_hold: got %b expected 1", busy); end
    checks++; if (data !== 8'hFF) begin errors++; $display("[TB] FAIL ferr_data_held: got %h expected ff", data); end
    rx = 1'b1;
    repeat (5) @(negedge sysclk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ferr_break_exit: got %b expected 0", busy); end
    send_frame(8'h12, 1'b1, fall);
    repeat (4) @(negedge sysclk);
    lat = (v_cyc.size() > base) ? v_cyc[base] - fall : -1;
    checks++; if (lat != LAT) begin errors++; $display("[TB] FAIL ferr_recover_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (data !== 8'h12) begin errors++; $display("[TB] FAIL ferr_recover_data: got %h expected 12", data); end
  endtask

  task automatic test_reset_mid_frame();
    int base, fe0, fall, lat;
    base = v_cyc.size(); fe0 = ferr_cnt;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    repeat (N / 2) @(negedge sysclk);
    rst_n = 1'b0;
    repeat (3) @(negedge sysclk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (data !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_data: got %h expected 00", data); end
    checks++; if (valid !== 1'b0 || frame_err !== 1'b0 || parity_err !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_strobes: got %b%b%b expected 000", valid, frame_err, parity_err); end
    rst_n = 1'b1;
    rx = 1'b1;
    repeat (2 * N) @(negedge sysclk);
    checks++; if (v_cyc.size() != base || ferr_cnt != fe0) begin errors++; $display("[TB] FAIL rstmid_no_strobe: got %0d expected 0", v_cyc.size() - base + ferr_cnt - fe0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_idle: got %b expected 0", busy); end
    send_frame(8'h81, 1'b1, fall);
    repeat (4) @(negedge sysclk);
    lat = (v_cyc.size() > base) ? v_cyc[base] - fall : -1;
    checks++; if (lat != LAT) begin errors++; $display("[TB] FAIL rstmid_next_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (data !== 8'h81) begin errors++; $display("[TB] FAIL rstmid_next_data: got %h expected 81", data); end
  endtask

`ifdef SERIAL_RX_PARITY_EN
  task automatic test_parity();
    int base, pe0, fe0;
    logic [7:0] b;
    b = 8'h07;
    base = v_cyc.size(); pe0 = perr_cnt; fe0 = ferr_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(~(^b));
    drive_bit(1'b1);
    repeat (4) @(negedge sysclk);
    checks++; if (perr_cnt - pe0 != 1) begin errors++; $display("[TB] FAIL parity_err_count: got %0d expected 1", perr_cnt - pe0); end
    checks++; if (v_cyc.size() != base) begin errors++; $display("[TB] FAIL parity_no_valid: got %0d expected 0", v_cyc.size() - base); end
    checks++; if (ferr_cnt != fe0) begin errors++; $display("[TB] FAIL parity_no_ferr: got %0d expected 0", ferr_cnt - fe0); end
    checks++; if (data !== 8'h81) begin errors++; $display("[TB] FAIL parity_data_held: got %h expected 81", data); end
  endtask
`endif

  initial begin
    @(negedge sysclk);
    test_reset();
    test_good_frame();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid_frame();
`ifdef SERIAL_RX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
